operand_sequencer: RTL and testbench

Initiator-side partner to the four-operand capture controller. It accepts one parallel request of four operands (A, B, C, D) over a valid/ready handshake and pulses start. It then streams A, B, C, D on a shared operand bus on four consecutive cycles, matching the capture_0..3 timing. It waits for the datapath's valid, latches the result and offers it on a response valid/ready handshake, with a timeout if valid never arrives.

---
 rtl/operand_sequencer.sv | 140 ++++++++++++++
 tb/tb_operand_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// operand_sequencer: sends A..D on a shared bus after start, waits for valid, returns result or timeout (optional SEQ_PROTOCOL_CHECK_EN adds proto_err)
module operand_sequencer #(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [WIDTH-1:0]     req_c,
  input  logic [WIDTH-1:0]     req_d,
  output logic                 start,
  output logic [WIDTH-1:0]     data_out,
  input  logic                 valid,
  input  logic [RES_WIDTH-1:0] result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RES_WIDTH-1:0] resp_result,
  output logic                 resp_timeout,
  output logic                 busy
`ifdef SEQ_PROTOCOL_CHECK_EN
  ,
  output logic                 proto_err
`endif
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SEND_A     = 3'd1;
  localparam logic [2:0] SEND_B     = 3'd2;
  localparam logic [2:0] SEND_C     = 3'd3;
  localparam logic [2:0] SEND_D     = 3'd4;
  localparam logic [2:0] WAIT_VALID = 3'd5;
  localparam logic [2:0] RESPOND    = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [RES_WIDTH-1:0] res_q, res_d;
  logic                 to_q, to_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 idle, timing_out;

  // Unused encodings behave exactly like IDLE so the FSM recovers on its own
  assign idle         = (state_q == IDLE) || (state_q > RESPOND);
  assign timing_out   = (state_q == WAIT_VALID) && !valid && (cnt_q == LAST);
  assign req_ready    = idle;
  assign busy         = !idle;
  assign start        = state_q == SEND_A;
  assign data_out     = (state_q == SEND_A) ? a_q :
                        (state_q == SEND_B) ? b_q :
                        (state_q == SEND_C) ? c_q :
                        (state_q == SEND_D) ? d_q : '0;
  assign resp_valid   = state_q == RESPOND;
  assign resp_result  = resp_valid ? res_q : '0;
  assign resp_timeout = resp_valid & to_q;

  // Next-state, operand capture, wait counter and result latch
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    res_d   = res_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEND_A: state_d = SEND_B;
      SEND_B: state_d = SEND_C;
      SEND_C: state_d = SEND_D;
      SEND_D: begin
        cnt_d   = '0;
        state_d = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (valid) begin
          res_d   = result;
          to_d    = 1'b0;
          state_d = RESPOND;
        end else if (cnt_q == LAST) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESPOND: state_d = resp_ready ? IDLE : RESPOND;
      default: begin
        state_d = req_valid ? SEND_A : IDLE;
        if (req_valid) begin
          a_d = req_a;
          b_d = req_b;
          c_d = req_c;
          d_d = req_d;
        end
      end
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      res_q   <= res_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEQ_PROTOCOL_CHECK_EN
  logic pe_q, pe_d;
  assign proto_err = pe_q;
  // Sticky flag: stray valid outside WAIT_VALID, or a timeout abort
  always_comb begin
    pe_d = pe_q | (valid && (state_q != WAIT_VALID)) | timing_out;
  end
  // Protocol error flag register, cleared only by reset
  always_ff @(posedge clock or posedge rst) begin
    if (rst) pe_q <= 1'b0;
    else     pe_q <= pe_d;
  end
`endif
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: table-driven plus directed corner-case bench for operand_sequencer
module tb_operand_sequencer;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [7:0]  req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic        start;
  logic [7:0]  data_out;
  logic        valid = 1'b0;
  logic [15:0] result = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_timeout, busy;
  logic [15:0] resp_result;
`ifdef SEQ_PROTOCOL_CHECK_EN
  logic        proto_err;
`endif
  int checks = 0, failures = 0;

  operand_sequencer #(.WIDTH(8), .RES_WIDTH(16), .TIMEOUT(8)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .start(start), .data_out(data_out), .valid(valid), .result(result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_timeout(resp_timeout), .busy(busy)
`ifdef SEQ_PROTOCOL_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rv;
    logic [7:0]  a, b, c, d;
    logic        vl;
    logic [15:0] res;
    logic        rr;
    logic        rdy, st;
    logic [7:0]  dout;
    logic        rsv;
    logic [15:0] rres;
    logic        rto, bsy;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic rv, logic [7:0] a, b, c, d, logic vl, logic [15:0] res, logic rr,
                              logic rdy, st, logic [7:0] dout, logic rsv, logic [15:0] rres, logic rto, bsy);
    vec_t v;
    v.rv = rv; v.a = a; v.b = b; v.c = c; v.d = d; v.vl = vl; v.res = res; v.rr = rr;
    v.rdy = rdy; v.st = st; v.dout = dout; v.rsv = rsv; v.rres = rres; v.rto = rto; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [7:0] a, b, c, d);
    req_valid = 1'b1; req_a = a; req_b = b; req_c = c; req_d = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_dout"}, 32'(data_out), 0);
    chk({tag, "_rsv"}, 32'(resp_valid), 0);
    chk({tag, "_rres"}, 32'(resp_result), 0);
    chk({tag, "_rto"}, 32'(resp_timeout), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rdy"}, 32'(req_ready), 1);
  endtask

  initial begin
    int n;
    tbl[0]  = mk(1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 16'h0,    0, 1, 0, 8'h00, 0, 16'h0,    0, 0);
    tbl[1]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 0, 1, 8'h11, 0, 16'h0,    0, 1);
    tbl[2]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 0, 0, 8'h22, 0, 16'h0,    0, 1);
    tbl[3]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 0, 0, 8'h33, 0, 16'h0,    0, 1);
    tbl[4]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 0, 0, 8'h44, 0, 16'h0,    0, 1);
    tbl[5]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 0, 0, 8'h00, 0, 16'h0,    0, 1);
    tbl[6]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 16'h0ABC, 0, 0, 0, 8'h00, 0, 16'h0,    0, 1);
    tbl[7]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 0, 0, 8'h00, 1, 16'h0ABC, 0, 1);
    tbl[8]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    1, 0, 0, 8'h00, 1, 16'h0ABC, 0, 1);
    tbl[9]  = mk(1, 8'h55, 8'h66, 8'h77, 8'h88, 0, 16'h0,    0, 1, 0, 8'h00, 0, 16'h0,    0, 0);
    tbl[10] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 0, 1, 8'h55, 0, 16'h0,    0, 1);
    tbl[11] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 16'hDEAD, 0, 0, 0, 8'h66, 0, 16'h0,    0, 1);
    tbl[12] = mk(1, 8'h99, 8'h99, 8'h99, 8'h99, 0, 16'h0,    0, 0, 0, 8'h77, 0, 16'h0,    0, 1);
    tbl[13] = mk(1, 8'h99, 8'h99, 8'h99, 8'h99, 0, 16'h0,    0, 0, 0, 8'h88, 0, 16'h0,    0, 1);
    tbl[14] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 16'h1234, 0, 0, 0, 8'h00, 0, 16'h0,    0, 1);
    tbl[15] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 16'hBEEF, 0, 0, 0, 8'h00, 1, 16'h1234, 0, 1);
    tbl[16] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    1, 0, 0, 8'h00, 1, 16'h1234, 0, 1);
    tbl[17] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0,    0, 1, 0, 8'h00, 0, 16'h0,    0, 0);

    #3;
    chk_reset_outs("reset");
`ifdef SEQ_PROTOCOL_CHECK_EN
    chk("reset_proto", 32'(proto_err), 0);
`endif
    @(negedge clock);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      req_valid = tbl[i].rv; req_a = tbl[i].a; req_b = tbl[i].b; req_c = tbl[i].c; req_d = tbl[i].d;
      valid = tbl[i].vl; result = tbl[i].res; resp_ready = tbl[i].rr;
      #1;
      chk($sformatf("row%0d_rdy", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_start", i), 32'(start), 32'(tbl[i].st));
      chk($sformatf("row%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
      chk($sformatf("row%0d_rsv", i), 32'(resp_valid), 32'(tbl[i].rsv));
      chk($sformatf("row%0d_rres", i), 32'(resp_result), 32'(tbl[i].rres));
      chk($sformatf("row%0d_rto", i), 32'(resp_timeout), 32'(tbl[i].rto));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      tick();
    end
    req_valid = 1'b0; valid = 1'b0; resp_ready = 1'b0;
`ifdef SEQ_PROTOCOL_CHECK_EN
    chk("stray_valid_proto", 32'(proto_err), 1);
`endif

    // Backpressure: RESPOND held, new request ignored meanwhile
    send_req(8'h01, 8'h02, 8'h03, 8'h04);
    repeat (4) tick();
    valid = 1'b1; result = 16'h0F0F;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_a = 8'hA1; req_b = 8'hA2; req_c = 8'hA3; req_d = 8'hA4;
      #1;
      chk($sformatf("bp%0d_rsv", k), 32'(resp_valid), 1);
      chk($sformatf("bp%0d_rres", k), 32'(resp_result), 32'h0F0F);
      chk($sformatf("bp%0d_rdy", k), 32'(req_ready), 0);
      chk($sformatf("bp%0d_start", k), 32'(start), 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_idle_rdy", 32'(req_ready), 1);
    chk("bp_idle_start", 32'(start), 0);
    chk("bp_idle_rsv", 32'(resp_valid), 0);
    tick();
    req_valid = 1'b0;
    chk("bp_next_start", 32'(start), 1);
    chk("bp_next_dout", 32'(data_out), 32'hA1);

    // Asynchronous reset in the middle of SEND_C
    tick();
    tick();
    chk("ar_sendc_dout", 32'(data_out), 32'hA3);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("ar");
`ifdef SEQ_PROTOCOL_CHECK_EN
    chk("ar_proto", 32'(proto_err), 0);
`endif
    @(negedge clock);
    rst = 1'b0;
    send_req(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    chk("ar_replay_start", 32'(start), 1);
    chk("ar_replay_dout", 32'(data_out), 32'hC1);

    // Timeout: valid never arrives
    repeat (4) tick();
    n = 0;
    while (!resp_valid && n < 20) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", 32'(n), 8);
    chk("to_rsv", 32'(resp_valid), 1);
    chk("to_rto", 32'(resp_timeout), 1);
    chk("to_rres", 32'(resp_result), 0);
`ifdef SEQ_PROTOCOL_CHECK_EN
    chk("to_proto", 32'(proto_err), 1);
`endif
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // valid on the last WAIT_VALID cycle wins over the timeout
    send_req(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    repeat (4) tick();
    repeat (7) tick();
    chk("last_still_wait", 32'(resp_valid), 0);
    valid = 1'b1; result = 16'h1234;
    tick();
    valid = 1'b0;
    chk("last_rsv", 32'(resp_valid), 1);
    chk("last_rto", 32'(resp_timeout), 0);
    chk("last_rres", 32'(resp_result), 32'h1234);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("last_idle_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
